// File: rtl/bidir_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : bidir_tx_arb
// Description : N-channel packet-granular round-robin TX arbiter. It produces
//               one registered AXI-stream output, with the source channel
//               carried on tuser, and truncates packets longer than MAXLEN.
//               Define BIDIR_TX_ARB_PRIO_EN to give channel 0 strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_tx_arb #(
    parameter int NCH    = 3,
    parameter int DW     = 32,
    parameter int MAXLEN = 256,
    localparam int CIDW  = $clog2(NCH),
    localparam int CW    = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    s_tvalid,
    output logic [NCH-1:0]    s_tready,
    input  logic [NCH*DW-1:0] s_tdata,
    input  logic [NCH-1:0]    s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tlast,
    output logic [CIDW-1:0]   m_tuser,
    output logic [NCH-1:0]    trunc_err,
    input  logic [NCH-1:0]    err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [CIDW-1:0]   r_grant;
    logic [CIDW-1:0]   r_last_grant;
    logic [CW-1:0]     r_beat_cnt;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic [DW-1:0]     r_m_tdata;
    logic [CIDW-1:0]   r_m_tuser;
    logic [NCH-1:0]    r_trunc_err;

    logic [NCH-1:0]    w_req;
    logic [NCH-1:0]    w_req_rr;
    logic              w_pick_vld;
    logic [CIDW-1:0]   w_pick;
    logic              w_g_valid;
    logic              w_g_last;
    logic [DW-1:0]     w_g_data;
    logic              w_xfer_rdy;
    logic              w_acc;
    logic              w_at_max;

    assign w_req = s_tvalid & ch_en;

`ifdef BIDIR_TX_ARB_PRIO_EN
    // Channel 0 is handled by strict priority, so it never takes part in the rotation.
    assign w_req_rr = w_req & {{(NCH-1){1'b1}}, 1'b0};
`else
    assign w_req_rr = w_req;
`endif

    // Scan from farthest to nearest, so the channel right after last_grant overrides the others.
    always_comb begin
        int idx;
        idx        = 0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % NCH;
            if (w_req_rr[idx[CIDW-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick     = CIDW'(idx);
            end
        end
`ifdef BIDIR_TX_ARB_PRIO_EN
        if (w_req[0]) begin
            w_pick_vld = 1'b1;
            w_pick     = '0;
        end
`endif
    end

    assign w_xfer_rdy = ~r_m_tvalid | m_tready;

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        s_tready  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_grant == CIDW'(i)) begin
                w_g_valid = s_tvalid[i];
                w_g_last  = s_tlast[i];
                w_g_data  = s_tdata[i*DW +: DW];
                if (r_state == ST_XFER)
                    s_tready[i] = w_xfer_rdy;
                else if (r_state == ST_DRAIN)
                    s_tready[i] = 1'b1;
            end
        end
    end

    assign w_acc    = (r_state == ST_XFER) & w_g_valid & w_xfer_rdy;
    assign w_at_max = (r_beat_cnt == CW'(MAXLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= CIDW'(NCH - 1);
            r_beat_cnt   <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tuser    <= '0;
            r_trunc_err  <= '0;
        end else begin
            r_trunc_err <= r_trunc_err & ~err_clr;

            if (w_acc) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_g_data;
                r_m_tuser  <= r_grant;
                r_m_tlast  <= w_g_last | w_at_max;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_g_last) begin
                            r_last_grant <= r_grant;
                            r_state      <= ST_IDLE;
                        end else if (w_at_max) begin
                            // Placed after the clear so that a simultaneous set wins.
                            r_trunc_err[r_grant] <= 1'b1;
                            r_state              <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_g_valid && w_g_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_tvalid  = r_m_tvalid;
    assign m_tdata   = r_m_tdata;
    assign m_tlast   = r_m_tlast;
    assign m_tuser   = r_m_tuser;
    assign trunc_err = r_trunc_err;

endmodule
`default_nettype wire
